// File: rtl/multi_tick_gen.sv
// multi_tick_gen: N-channel divider tick source with run/pause, clear, one-shot and runtime divisor reload.
module multi_tick_gen #(
  parameter int N_CH = 4,
  parameter int CNT_W = 27,
  parameter int DEF_DIV = 1_000_000,
  localparam int LW = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  i_run,
  input  logic [N_CH-1:0]  i_clear,
  input  logic [N_CH-1:0]  i_oneshot,
  input  logic             i_load,
  input  logic [LW-1:0]    i_load_ch,
  input  logic [CNT_W-1:0] i_load_div,
  output logic [N_CH-1:0]  o_tick,
  output logic [N_CH-1:0]  o_busy,
  output logic             o_div_err
);
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [CNT_W-1:0] div_q [N_CH];
  logic [CNT_W-1:0] div_d [N_CH];
  logic [N_CH-1:0]  done_q, done_d, tick_q, tick_d, busy_q, busy_d;
  logic             div_err_q, div_err_d, ld_ok;
  always_comb begin
    ld_ok = i_load && (32'(i_load_ch) < N_CH) && (i_load_div >= CNT_W'(2));
    div_err_d = i_load && !ld_ok;
    for (int c = 0; c < N_CH; c++) begin
      cnt_d[c] = cnt_q[c];
      div_d[c] = div_q[c];
      done_d[c] = done_q[c];
      tick_d[c] = 1'b0;
      busy_d[c] = i_run[c] && !done_q[c];
      if (ld_ok && 32'(i_load_ch) == c) begin
        div_d[c] = i_load_div;
        cnt_d[c] = '0;
        done_d[c] = 1'b0;
      end else if (i_clear[c]) begin
        cnt_d[c] = '0;
        done_d[c] = 1'b0;
      end else if (i_run[c] && !done_q[c]) begin
        tick_d[c] = cnt_q[c] == div_q[c] - CNT_W'(1);
        cnt_d[c] = tick_d[c] ? '0 : cnt_q[c] + CNT_W'(1);
        done_d[c] = tick_d[c] && i_oneshot[c];
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        cnt_q[c] <= '0;
        div_q[c] <= CNT_W'(DEF_DIV);
      end
      done_q <= '0;
      tick_q <= '0;
      busy_q <= '0;
      div_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      done_q <= done_d;
      tick_q <= tick_d;
      busy_q <= busy_d;
      div_err_q <= div_err_d;
    end
  end
  assign o_tick = tick_q;
  assign o_busy = busy_q;
  assign o_div_err = div_err_q;
endmodule

// File: tb/tb_multi_tick_gen.sv
// tb_multi_tick_gen: scoreboard bench; a countdown reference model queues per-cycle expectations.
module tb_multi_tick_gen;
  logic       clk = 0, rst = 1;
  logic [2:0] i_run = 0, i_clear = 0, i_oneshot = 0;
  logic       i_load = 0;
  logic [1:0] i_load_ch = 0;
  logic [7:0] i_load_div = 0;
  logic [2:0] o_tick, o_busy;
  logic       o_div_err;
  int total = 0, bad = 0;
  typedef struct { logic [2:0] t; logic [2:0] b; logic e; } exp_t;
  exp_t q[$];
  int rem[3], mdiv[3];
  bit mdone[3];
  int ticks0 = 0;

  multi_tick_gen #(.N_CH(3), .CNT_W(8), .DEF_DIV(5)) dut (
    .clk(clk), .rst(rst), .i_run(i_run), .i_clear(i_clear), .i_oneshot(i_oneshot),
    .i_load(i_load), .i_load_ch(i_load_ch), .i_load_div(i_load_div),
    .o_tick(o_tick), .o_busy(o_busy), .o_div_err(o_div_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      rem[c] = 5;
      mdiv[c] = 5;
      mdone[c] = 0;
    end
    q.delete();
  endtask

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      exp_t e, g;
      e.t = 0;
      e.b = 0;
      e.e = i_load && !(i_load_ch < 3 && i_load_div >= 2);
      for (int c = 0; c < 3; c++) begin
        e.b[c] = i_run[c] && !mdone[c];
        if (i_load && i_load_ch == c && i_load_div >= 2) begin
          mdiv[c] = i_load_div;
          rem[c] = i_load_div;
          mdone[c] = 0;
        end else if (i_clear[c]) begin
          rem[c] = mdiv[c];
          mdone[c] = 0;
        end else if (i_run[c] && !mdone[c]) begin
          if (rem[c] == 1) begin
            e.t[c] = 1;
            rem[c] = mdiv[c];
            mdone[c] = i_oneshot[c];
          end else rem[c]--;
        end
      end
      q.push_back(e);
      @(posedge clk);
      #1;
      g = q.pop_front();
      chk("tick", 32'(o_tick), 32'(g.t));
      chk("busy", 32'(o_busy), 32'(g.b));
      chk("div_err", 32'(o_div_err), 32'(g.e));
      if (o_tick[0]) ticks0++;
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tick", 32'(o_tick), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_err", 32'(o_div_err), 0);
    rst = 0;
    // ch0 periodic: ticks land on the 5th and 10th cycles
    i_run = 3'b001;
    cyc(12);
    chk("ch0_tick_count", 32'(ticks0), 2);
    // pause and resume
    cyc(3);
    i_run = 3'b000;
    cyc(10);
    i_run = 3'b001;
    cyc(8);
    // clear mid-count, then clear colliding with a would-be tick
    i_clear = 3'b001;
    cyc();
    i_clear = 0;
    cyc(7);
    for (int k = 0; k < 10 && rem[0] != 1; k++) cyc();
    chk("ch0_at_last_count", 32'(rem[0]), 1);
    i_clear = 3'b001;
    cyc();
    chk("clear_suppresses_tick", 32'(o_tick[0]), 0);
    i_clear = 0;
    cyc(6);
    // divisor loads
    i_run = 3'b111;
    cyc(3);
    i_load = 1; i_load_ch = 1; i_load_div = 3;
    cyc();
    i_load = 0;
    cyc(10);
    i_load = 1; i_load_ch = 1; i_load_div = 1;
    cyc();
    chk("err_div1", 32'(o_div_err), 1);
    i_load = 1; i_load_ch = 3; i_load_div = 4;
    cyc();
    chk("err_ch3", 32'(o_div_err), 1);
    i_load = 0;
    cyc(8);
    // one-shot on ch2
    i_oneshot = 3'b100;
    i_clear = 3'b100;
    cyc();
    i_clear = 0;
    cyc(25);
    chk("oneshot_idle", 32'(o_busy[2]), 0);
    i_clear = 3'b100;
    cyc();
    i_clear = 0;
    cyc(8);
    // async reset mid-count with ch1 at div 3
    i_oneshot = 0;
    i_load = 1; i_load_ch = 1; i_load_div = 3;
    cyc();
    i_load = 0;
    cyc(4);
    #2 rst = 1;
    #1;
    chk("arst_tick", 32'(o_tick), 0);
    chk("arst_busy", 32'(o_busy), 0);
    chk("arst_err", 32'(o_div_err), 0);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    cyc(12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/multi_tick_gen.md
# multi_tick_gen

Parametrised, multi-channel tick generator for the watch/stopwatch datapath. It generalises the single-channel fixed-rate run/stop tick source: each of N_CH channels has its own run/pause, synchronous clear, and one-shot mode. Each channel's divisor can be reloaded at runtime over a simple load strobe. Outputs are registered single-cycle tick pulses for downstream time counters.

## Interface
- N_CH, 4, number of independent tick channels (≥2)
- CNT_W, 27, counter/divisor width in bits
- DEF_DIV, 1_000_000, reset divisor for every channel (100 Hz at 100 MHz); 2 ≤ DEF_DIV < 2^CNT_W
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- i_run  in  N_CH  per-channel run (1) / pause (0), level
- i_clear  in  N_CH  per-channel synchronous clear, level
- i_oneshot  in  N_CH  per-channel mode: 0 periodic, 1 single tick then stop
- i_load  in  1  divisor load strobe, one cycle
- i_load_ch  in  max(1,$clog2(N_CH))  target channel of load
- i_load_div  in  CNT_W  new divisor value
- o_tick  out  N_CH  registered tick pulse, one cycle wide
- o_busy  out  N_CH  channel actively counting: i_run & ~done, registered
- o_div_err  out  1  one-cycle pulse: load rejected

## Operation
- Per-channel state: counter cnt[CNT_W], divisor div[CNT_W], done flag.
- Priority per channel, highest first: rst, load targeting channel, i_clear, run/count.
- Load accepted if i_load_ch < N_CH and i_load_div ≥ 2: div ← i_load_div, cnt ← 0, done ← 0, tick ← 0. Other channels are unaffected.
- Load rejected (div 0/1 or channel out of range): o_div_err = 1 next cycle. No state changes and no counting disturbance on any channel.
- i_clear=1: cnt ← 0, done ← 0, tick ← 0, regardless of i_run.
- Run state (i_run=1, done=0):
  - cnt == div−1: cnt ← 0, tick ← 1, done ← i_oneshot.
  - otherwise: cnt ← cnt+1, tick ← 0.
- Pause (i_run=0): cnt holds, tick ← 0. Phase is preserved across a pause.
- Done (done=1): cnt holds 0, tick ← 0 until clear or an accepted load. Changing i_oneshot alone does not restart the channel.
- Comparison is against div−1 in CNT_W bits. The counter never exceeds div−1, so there is no wrap beyond the divisor.

## Timing
- Reset values:
  - o_tick = 0, o_busy = 0, o_div_err = 0
  - every cnt = 0, every div = DEF_DIV, every done = 0
- Periodic mode, run held high: o_tick is high for exactly 1 cycle every div cycles.
- First tick is high in the div-th cycle after the first rising edge that samples i_run=1 from cnt=0.
- Pause: ticks occur after div cumulative run cycles; paused cycles do not count.
- Tick latency from cnt == div−1 sampled: 1 cycle, registered output.
- o_busy reflects i_run & ~done with 1 cycle of latency.
- Load, clear and a would-be tick in the same cycle: load/clear wins and the tick is suppressed.
- Async rst mid-count: all outputs drop to 0 immediately and the divisors revert to DEF_DIV.

## Test plan
All scenarios use N_CH=3, CNT_W=8, DEF_DIV=5.
- Reset, then i_run[0]=1 held → o_tick[0] pulses 1 cycle wide, first in the 5th cycle, then every 5 cycles. o_tick[2:1]=0, o_busy=3'b001.
- Pause/resume on ch0: run 3 cycles, pause 10, resume → next tick after 2 more run cycles. No ticks while paused.
- Clear on ch0:
  - i_clear[0] pulse at cnt=3 with run high → next tick 5 cycles after clear release.
  - Clear in the same cycle as cnt=4 → no tick that cycle.
- Divisor load:
  - Load ch1 div=3 while all channels run → ch1 period becomes 3, restarting from 0; ch0/ch2 keep period 5 with phase unchanged.
  - Load div=1 → o_div_err 1-cycle pulse, ch1 still period 3.
  - Load ch index 3 → o_div_err pulse, no change.
- One-shot on ch2: i_oneshot[2]=1, run=1 → exactly one tick after 5 cycles, o_busy[2] → 0, no further ticks for 20 cycles. i_clear[2] pulse → one more tick 5 cycles later.
- Async rst asserted mid-count with ch1 at div=3 → o_tick/o_busy = 0 immediately. After release and run → ch1 period back to 5.
